// File: rtl/fifo_led_pkg.sv
// Shared types and width helpers for the FIFO status LED controller.
package fifo_led_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_ON  = 2'd1,
    PULSE_OFF = 2'd2,
    GAP       = 2'd3
  } blink_state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Bits needed to hold values 0..max_value, never narrower than one bit.
  function automatic int bits_for(input int max_value);
    int w;
    w = clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_pulse_stretch.sv
// Holds an LED on for STRETCH_TICKS ticks after its source level drops.
module led_pulse_stretch
  import fifo_led_pkg::*;
#(
  parameter int STRETCH_TICKS = 2
) (
  input  logic led_clk,
  input  logic sys_rst,
  input  logic src,
  input  logic tick,
  output logic led
);

  localparam int HW = bits_for(STRETCH_TICKS);

  logic [HW-1:0] hold;

  // With no tick (run enable low) the hold simply freezes and the LED stays lit.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold <= '0;
      led  <= 1'b0;
    end else if (src) begin
      hold <= HW'(STRETCH_TICKS);
      led  <= 1'b1;
    end else if (tick && (hold != '0)) begin
      hold <= hold - HW'(1);
      led  <= (hold != HW'(1));
    end
  end

endmodule

// File: rtl/fifo_status_led_ctrl.sv
// Multi-channel FIFO health indicator: heartbeat, sticky per-channel errors
// blinked out as a channel code, and pulse-stretched full/empty LEDs.
//
// state     | meaning
// IDLE      | no burst running; waits for a tick while an error is latched
// PULSE_ON  | error LED lit for PULSE_TICKS ticks
// PULSE_OFF | error LED dark for PULSE_TICKS ticks between pulses
// GAP       | error LED dark for CODE_GAP_TICKS ticks after a burst
module fifo_status_led_ctrl
  import fifo_led_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGE     = 2,
  parameter int TICK_DIV       = 1048576,
  parameter int PULSE_TICKS    = 1,
  parameter int CODE_GAP_TICKS = 4,
  parameter int STRETCH_TICKS  = 2,
  localparam int CW            = bits_for(NUM_CH)
) (
  input  logic              led_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_error,
  input  logic [NUM_CH-1:0] ch_full,
  input  logic [NUM_CH-1:0] ch_empty,
  input  logic              err_clr,
  output logic              led_blink,
  output logic              led_error,
  output logic              led_full,
  output logic              led_empty,
  output logic [NUM_CH-1:0] err_mask,
  output logic [CW-1:0]     err_code
);

  localparam int SW  = 3 * NUM_CH + 1;
  localparam int TCW = bits_for(TICK_DIV - 1);
  localparam int PW  = bits_for((PULSE_TICKS > CODE_GAP_TICKS) ? PULSE_TICKS : CODE_GAP_TICKS);

  logic [SW-1:0]     sync_in;
  logic [SW-1:0]     sync_out;
  logic              enable_s;
  logic [NUM_CH-1:0] ch_error_s;
  logic [NUM_CH-1:0] ch_full_s;
  logic [NUM_CH-1:0] ch_empty_s;

  assign sync_in = {enable, ch_error, ch_full, ch_empty};

  for (genvar b = 0; b < SW; b++) begin : g_sync
    logic [SYNC_STAGE-1:0] chain;
    always_ff @(posedge led_clk or posedge sys_rst) begin
      if (sys_rst) chain <= '0;
      else         chain <= {chain[SYNC_STAGE-2:0], sync_in[b]};
    end
    assign sync_out[b] = chain[SYNC_STAGE-1];
  end

  assign {enable_s, ch_error_s, ch_full_s, ch_empty_s} = sync_out;

  logic [TCW-1:0] tick_cnt;
  logic           tick;

  assign tick = enable_s && (tick_cnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tick_cnt  <= '0;
      led_blink <= 1'b0;
    end else begin
      if (!enable_s || tick) tick_cnt <= '0;
      else                   tick_cnt <= tick_cnt + TCW'(1);
      if (tick) led_blink <= ~led_blink;
    end
  end

  // A channel still reporting an error re-sets its bit in the same cycle as a clear.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) err_mask <= '0;
    else         err_mask <= (err_mask & ~{NUM_CH{err_clr}}) | ch_error_s;
  end

  always_comb begin
    err_code = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_mask[i]) err_code = CW'(i + 1);
    end
  end

  blink_state_t  state;
  blink_state_t  state_nxt;
  logic [PW-1:0] tcnt;
  logic [PW-1:0] tcnt_nxt;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] pcnt_nxt;
  logic          led_error_nxt;

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      pcnt      <= '0;
      led_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      pcnt      <= pcnt_nxt;
      led_error <= led_error_nxt;
    end
  end

  // tcnt is a per-phase down-counter in ticks; the phase ends on the tick seen at zero.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    pcnt_nxt  = pcnt;
    if (err_clr) begin
      state_nxt = IDLE;
      tcnt_nxt  = '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (err_mask != '0) begin
            state_nxt = PULSE_ON;
            pcnt_nxt  = err_code;
            tcnt_nxt  = PW'(PULSE_TICKS - 1);
          end
        end
        PULSE_ON: begin
          if (tcnt == '0) begin
            state_nxt = PULSE_OFF;
            pcnt_nxt  = pcnt - CW'(1);
            tcnt_nxt  = PW'(PULSE_TICKS - 1);
          end else begin
            tcnt_nxt = tcnt - PW'(1);
          end
        end
        PULSE_OFF: begin
          if (tcnt == '0) begin
            if (pcnt == '0) begin
              state_nxt = GAP;
              tcnt_nxt  = PW'(CODE_GAP_TICKS - 1);
            end else begin
              state_nxt = PULSE_ON;
              tcnt_nxt  = PW'(PULSE_TICKS - 1);
            end
          end else begin
            tcnt_nxt = tcnt - PW'(1);
          end
        end
        GAP: begin
          if (tcnt == '0) state_nxt = IDLE;
          else            tcnt_nxt  = tcnt - PW'(1);
        end
        default: begin
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Decoding the next state keeps led_error registered yet aligned with the state.
  always_comb begin
    led_error_nxt = (state_nxt == PULSE_ON);
  end

  led_pulse_stretch #(
    .STRETCH_TICKS(STRETCH_TICKS)
  ) u_full_stretch (
    .led_clk(led_clk),
    .sys_rst(sys_rst),
    .src    (|ch_full_s),
    .tick   (tick),
    .led    (led_full)
  );

  led_pulse_stretch #(
    .STRETCH_TICKS(STRETCH_TICKS)
  ) u_empty_stretch (
    .led_clk(led_clk),
    .sys_rst(sys_rst),
    .src    (|ch_empty_s),
    .tick   (tick),
    .led    (led_empty)
  );

endmodule

// File: tb/tb_fifo_status_led_ctrl.sv
// Directed bench for fifo_status_led_ctrl with TICK_DIV=4; edge numbers count
// led_clk rising edges after reset release, expected values worked out by hand.
module tb_fifo_status_led_ctrl;

  logic       led_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       enable   = 1'b0;
  logic       err_clr  = 1'b0;
  logic [3:0] ch_error = '0;
  logic [3:0] ch_full  = '0;
  logic [3:0] ch_empty = '0;
  logic       led_blink;
  logic       led_error;
  logic       led_full;
  logic       led_empty;
  logic [3:0] err_mask;
  logic [2:0] err_code;

  int n_cmp  = 0;
  int n_err  = 0;
  int edge_n = 0;

  fifo_status_led_ctrl #(
    .NUM_CH        (4),
    .SYNC_STAGE    (2),
    .TICK_DIV      (4),
    .PULSE_TICKS   (1),
    .CODE_GAP_TICKS(4),
    .STRETCH_TICKS (2)
  ) dut (
    .led_clk  (led_clk),
    .sys_rst  (sys_rst),
    .enable   (enable),
    .ch_error (ch_error),
    .ch_full  (ch_full),
    .ch_empty (ch_empty),
    .err_clr  (err_clr),
    .led_blink(led_blink),
    .led_error(led_error),
    .led_full (led_full),
    .led_empty(led_empty),
    .err_mask (err_mask),
    .err_code (err_code)
  );

  always #5 led_clk = ~led_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge n.
  task automatic go(input int n);
    if (edge_n < n) begin
      while (edge_n < n) begin
        @(posedge led_clk);
        edge_n++;
      end
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge led_clk);
    #1;
    chk("rst_blink", led_blink, 0);
    chk("rst_error", led_error, 0);
    chk("rst_full",  led_full,  0);
    chk("rst_empty", led_empty, 0);
    chk("rst_mask",  err_mask,  0);
    chk("rst_code",  err_code,  0);
    sys_rst = 1'b0;
    enable  = 1'b1;
    edge_n  = 0;

    // Heartbeat: ticks land on edges 6, 10, 14
    go(5);  chk("hb_pre_tick", led_blink, 0);
    go(6);  chk("hb_tick1", led_blink, 1);
    go(9);  chk("hb_hold", led_blink, 1);
    go(10); chk("hb_tick2", led_blink, 0);
    go(14); chk("hb_tick3", led_blink, 1);
    enable = 1'b0;
    go(18); chk("hb_dis18", led_blink, 1);
    go(22); chk("hb_dis22", led_blink, 1);
    go(24); enable = 1'b1;
    go(29); chk("hb_reen_pre", led_blink, 1);
    go(30); chk("hb_reen_tick", led_blink, 0);

    // Single error on channel 2 -> code 3; ticks on edges 2 mod 4
    go(32); ch_error = 4'b0100;
    go(33); ch_error = 4'b0000;
    go(34); chk("e2_mask_lat", err_mask, 4'b0000);
    go(35); chk("e2_mask", err_mask, 4'b0100);
            chk("e2_code", err_code, 3);
    go(37); chk("e2_idle", led_error, 0);
    go(38); chk("e2_on1", led_error, 1);
    go(41); chk("e2_on1_end", led_error, 1);
    go(42); chk("e2_off1", led_error, 0);
    go(46); chk("e2_on2", led_error, 1);
    go(54); chk("e2_on3", led_error, 1);
    go(58); chk("e2_off3", led_error, 0);
    go(62); chk("e2_gap", led_error, 0);
    go(77); chk("e2_gap_end", led_error, 0);
    go(81); chk("e2_idle2", led_error, 0);
    go(82); chk("e2_burst2", led_error, 1);

    // Clear during PULSE_ON, then channels 1 and 2 -> code 2
    go(83); err_clr = 1'b1;
    go(84); err_clr = 1'b0;
            chk("clr_led", led_error, 0);
            chk("clr_mask", err_mask, 0);
            chk("clr_code", err_code, 0);
            ch_error = 4'b0110;
    go(85); ch_error = 4'b0000;
    go(86); chk("e3_no_start", led_error, 0);
    go(87); chk("e3_mask", err_mask, 4'b0110);
            chk("e3_code", err_code, 2);
    go(90);  chk("e3_on1", led_error, 1);
    go(94);  chk("e3_off1", led_error, 0);
    go(98);  chk("e3_on2", led_error, 1);
    go(102); chk("e3_off2", led_error, 0);
    go(106); chk("e3_gap", led_error, 0);
    go(122); chk("e3_idle", led_error, 0);
    go(126); chk("e3_burst2", led_error, 1);
    err_clr = 1'b1;
    go(127); err_clr = 1'b0;
             chk("e3_clr_led", led_error, 0);
             chk("e3_clr_mask", err_mask, 0);
             chk("e3_clr_code", err_code, 0);
    go(130); chk("e3_stay_idle", led_error, 0);

    // Set beats clear on channel 0
    ch_error = 4'b0001;
    go(133); chk("e4_mask", err_mask, 4'b0001);
    go(134); chk("e4_on", led_error, 1);
             err_clr = 1'b1;
    go(135); err_clr = 1'b0;
             chk("e4_set_wins", err_mask, 4'b0001);
             chk("e4_code", err_code, 1);
             chk("e4_clr_idle", led_error, 0);
    go(138); chk("e4_restart", led_error, 1);
    go(140); ch_error = 4'b0000;
    go(142); chk("e4_off", led_error, 0);
    go(146); chk("e4_gap", led_error, 0);
             err_clr = 1'b1;
    go(147); err_clr = 1'b0;
             chk("e4_cleared", err_mask, 0);

    // Full/empty stretch: src seen on edges 151..153, ticks at 154 and 158
    go(148); ch_full = 4'b0010; ch_empty = 4'b1000;
    go(150); chk("st_full_pre", led_full, 0);
             chk("st_empty_pre", led_empty, 0);
    go(151); ch_full = 4'b0000; ch_empty = 4'b0000;
             chk("st_full_rise", led_full, 1);
             chk("st_empty_rise", led_empty, 1);
    go(157); chk("st_full_hold", led_full, 1);
             chk("st_empty_hold", led_empty, 1);
    go(158); chk("st_full_drop", led_full, 0);
             chk("st_empty_drop", led_empty, 0);

    // Stretch freezes while disabled
    go(160); ch_full = 4'b0001;
    go(161); ch_full = 4'b0000;
    go(163); chk("fz_full_rise", led_full, 1);
             chk("fz_empty_quiet", led_empty, 0);
    go(166); enable = 1'b0;
    go(175); chk("fz_hold", led_full, 1);
    go(176); enable = 1'b1;
    go(181); chk("fz_hold_reen", led_full, 1);
    go(182); chk("fz_drop", led_full, 0);

    // Async reset mid-burst, error kept asserted
    ch_error = 4'b0001;
    go(185); chk("rs_mask_pre", err_mask, 4'b0001);
    go(186); chk("rs_on", led_error, 1);
    go(187);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("rs_error", led_error, 0);
    chk("rs_blink", led_blink, 0);
    chk("rs_full",  led_full,  0);
    chk("rs_empty", led_empty, 0);
    chk("rs_mask",  err_mask,  0);
    chk("rs_code",  err_code,  0);
    go(189); sys_rst = 1'b0;
    go(191); chk("rs_mask_sync", err_mask, 0);
    go(192); chk("rs_relatch", err_mask, 4'b0001);
             chk("rs_code1", err_code, 1);
    go(194); chk("rs_idle", led_error, 0);
    go(195); chk("rs_burst", led_error, 1);
             chk("rs_blink_tick", led_blink, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
